// File: rtl/data_fetch.sv
// data_fetch: DDR3 read engine streaming a run of ring-region bursts through a FWFT FIFO; define RD_LEN_CHECK_EN to enable burst-length checking
module data_fetch #(
  parameter logic [31:0] ch1_base_addr       = 32'h80000000,
  parameter logic [31:0] ch1_end_addr        = 32'h9FFFFF80,
  parameter logic [31:0] ch2_base_addr       = 32'hA0000000,
  parameter logic [31:0] ch2_end_addr        = 32'hBFFFFF80,
  parameter logic [31:0] algorithm_base_addr = 32'h80000000,
  parameter logic [31:0] algorithm_end_addr  = 32'hBFFFFF80,
  parameter int          burst_rd_length     = 128,
  parameter logic [31:0] addr_increase_pace  = 32'd128,
  parameter int          fifo_depth_log2     = 8
) (
  input  logic                       ddr3_user_clk,
  input  logic                       ddr3_ui_rst,
  input  logic                       start,
  input  logic [1:0]                 ch_sel,
  input  logic [31:0]                start_addr,
  input  logic [15:0]                num_bursts,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                rd_addr_0,
  output logic [19:0]                rd_len_0,
  output logic                       rd_valid_0,
  input  logic                       rd_ready_0,
  input  logic [127:0]               rd_data_0,
  input  logic                       rd_data_valid_0,
  input  logic                       rd_data_end_0,
  output logic [127:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [fifo_depth_log2:0]   fifo_count,
  output logic                       ovf_err,
  output logic                       len_err
);
  localparam int depth = 1 << fifo_depth_log2;
  typedef enum logic [2:0] {IDLE, CHECK, CMD, DATA, DONE} state_t;
  state_t state;
  logic [1:0] ch;
  logic [15:0] remain;
  logic [31:0] base_sel, end_sel, next_addr;
  logic [fifo_depth_log2-1:0] wr_ptr, rd_ptr;
  logic [127:0] mem [depth];
  logic push, wr_en, pop, full, credit_ok, last_beat;
  assign rd_len_0  = 20'(burst_rd_length);
  assign base_sel  = ch == 2'd1 ? ch2_base_addr : ch == 2'd2 ? algorithm_base_addr : ch1_base_addr;
  assign end_sel   = ch == 2'd1 ? ch2_end_addr : ch == 2'd2 ? algorithm_end_addr : ch1_end_addr;
  assign next_addr = rd_addr_0 == end_sel ? base_sel : rd_addr_0 + addr_increase_pace;
  assign full      = fifo_count == {1'b1, {fifo_depth_log2{1'b0}}};
  assign push      = rd_data_valid_0 && state == DATA;
  assign wr_en     = push && !full;
  assign pop       = out_ready && out_valid;
  assign last_beat = push && rd_data_end_0;
  assign credit_ok = (depth - int'(fifo_count)) >= burst_rd_length;
  assign out_valid = fifo_count != '0;
  assign out_data  = mem[rd_ptr];
  // command sequencer: one burst in flight, next one only when the FIFO has room for a whole burst
  always_ff @(posedge ddr3_user_clk) begin
    if (ddr3_ui_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_valid_0 <= 1'b0;
      rd_addr_0  <= ch1_base_addr;
      ch         <= 2'd0;
      remain     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && ch_sel != 2'd3) begin
          if (num_bursts == '0) done <= 1'b1;
          else begin
            ch        <= ch_sel;
            rd_addr_0 <= start_addr;
            remain    <= num_bursts;
            busy      <= 1'b1;
            state     <= CHECK;
          end
        end
        CHECK: if (credit_ok) begin
          rd_valid_0 <= 1'b1;
          state      <= CMD;
        end
        CMD: if (rd_ready_0) begin
          rd_valid_0 <= 1'b0;
          state      <= DATA;
        end
        DATA: if (last_beat) begin
          rd_addr_0 <= next_addr;
          remain    <= remain - 16'd1;
          if (remain == 16'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else state <= CHECK;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge ddr3_user_clk) begin
    if (ddr3_ui_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      ovf_err    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && full) ovf_err <= 1'b1;
      fifo_count <= fifo_count + (fifo_depth_log2+1)'(wr_en) - (fifo_depth_log2+1)'(pop);
    end
  end
  // FIFO storage, no reset needed since occupancy gates every read
  always_ff @(posedge ddr3_user_clk) begin
    if (wr_en) mem[wr_ptr] <= rd_data_0;
  end
`ifdef RD_LEN_CHECK_EN
  logic [19:0] beat_cnt;
  // per-burst beat count; flags short/long bursts and beats arriving outside a read
  always_ff @(posedge ddr3_user_clk) begin
    if (ddr3_ui_rst) begin
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else if (rd_data_valid_0) begin
      if (state != DATA) len_err <= 1'b1;
      else if (rd_data_end_0) begin
        beat_cnt <= '0;
        if (beat_cnt + 20'd1 != rd_len_0) len_err <= 1'b1;
      end else beat_cnt <= beat_cnt + 20'd1;
    end
  end
`else
  assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_data_fetch.sv
// tb_data_fetch: randomized self-checking bench for data_fetch against a queue-based behavioural model
module tb_data_fetch;
  localparam int depth = 256;
`ifdef RD_LEN_CHECK_EN
  localparam bit len_chk = 1'b1;
`else
  localparam bit len_chk = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0;
  logic [1:0] ch_sel = '0;
  logic [31:0] start_addr = '0;
  logic [15:0] num_bursts = '0;
  logic busy, done, rd_valid_0, out_valid, ovf_err, len_err;
  logic [31:0] rd_addr_0;
  logic [19:0] rd_len_0;
  logic rd_ready_0 = 1'b0, rd_data_valid_0 = 1'b0, rd_data_end_0 = 1'b0, out_ready = 1'b0;
  logic [127:0] rd_data_0 = '0;
  logic [127:0] out_data;
  logic [8:0] fifo_count;

  data_fetch dut (
    .ddr3_user_clk(clk), .ddr3_ui_rst(rst), .start(start), .ch_sel(ch_sel),
    .start_addr(start_addr), .num_bursts(num_bursts), .busy(busy), .done(done),
    .rd_addr_0(rd_addr_0), .rd_len_0(rd_len_0), .rd_valid_0(rd_valid_0),
    .rd_ready_0(rd_ready_0), .rd_data_0(rd_data_0), .rd_data_valid_0(rd_data_valid_0),
    .rd_data_end_0(rd_data_end_0), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .ovf_err(ovf_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total_cnt = 0;
  logic [127:0] q[$];
  logic [31:0] exp_addrs[$], cmd_log[$];
  bit m_busy = 0, m_done = 0, m_len_err = 0, chk_en = 0, short_next = 0, burst_short = 0, prev_acc = 0;
  int bursts_left = 0, beat_left = 0, lat = 0, or_mode = 1, rdy_mode = 1;
  int stall_seen = 0, pop_cnt = 0, done_cnt = 0, prev_cnt = 0;
  logic prev_valid = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] nxt(input logic [1:0] c, input logic [31:0] a);
    logic [31:0] b, e;
    b = c == 2'd1 ? 32'hA0000000 : 32'h80000000;
    e = c == 2'd0 ? 32'h9FFFFF80 : 32'hBFFFFF80;
    return a == e ? b : a + 32'd128;
  endfunction

  // compare DUT outputs against the model after every rising edge
  always @(negedge clk) if (chk_en) begin
    chk("busy", 128'(busy), 128'(m_busy));
    chk("done", 128'(done), 128'(m_done));
    chk("fifo_count", 128'(fifo_count), 128'(q.size()));
    chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("ovf_err", 128'(ovf_err), 128'(0));
    chk("len_err", 128'(len_err), 128'(m_len_err));
    if (!m_busy || beat_left > 0 || exp_addrs.size() == 0) chk("rd_valid_idle", 128'(rd_valid_0), 128'(0));
    if (rd_valid_0 && !prev_valid) chk("credit", 128'(prev_cnt <= depth - 128), 128'(1));
    if (rd_valid_0 && prev_valid && !prev_acc) chk("addr_stable", 128'(rd_addr_0), 128'(prev_addr));
    if (done) done_cnt++;
    prev_valid = rd_valid_0;
    prev_addr = rd_addr_0;
    prev_cnt = q.size();
  end

  task automatic step(input bit do_start, input logic [1:0] c, input logic [31:0] a, input logic [15:0] n, input bit do_rst);
    bit pop, acc;
    logic [31:0] x;
    @(negedge clk);
    #1;
    rst = do_rst;
    start = do_start;
    ch_sel = c;
    start_addr = a;
    num_bursts = n;
    out_ready = or_mode == 1 || (or_mode == 2 && $urandom_range(1) == 1);
    rd_ready_0 = rdy_mode == 1 || (rdy_mode == 0 && $urandom_range(1) == 1) || (rdy_mode == 2 && stall_seen >= 10);
    if (rdy_mode == 2 && rd_valid_0 && !rd_ready_0) stall_seen++;
    rd_data_valid_0 = 1'b0;
    rd_data_end_0 = 1'b0;
    m_done = 0;
    if (do_rst) begin
      q.delete();
      exp_addrs.delete();
      m_busy = 0;
      m_len_err = 0;
      beat_left = 0;
      lat = 0;
      prev_acc = 0;
      return;
    end
    pop = out_ready && q.size() != 0;
    if (pop) begin
      void'(q.pop_front());
      pop_cnt++;
    end
    if (beat_left > 0) begin
      if (lat > 0) lat--;
      else if ($urandom_range(3) != 0) begin
        rd_data_valid_0 = 1'b1;
        rd_data_0 = {$urandom, $urandom, $urandom, $urandom};
        rd_data_end_0 = beat_left == 1;
        q.push_back(rd_data_0);
        beat_left--;
        if (beat_left == 0) begin
          if (burst_short && len_chk) m_len_err = 1;
          bursts_left--;
          if (bursts_left == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
    acc = rd_valid_0 && rd_ready_0;
    prev_acc = acc;
    if (acc) begin
      cmd_log.push_back(rd_addr_0);
      chk("cmd_expected", 128'(exp_addrs.size() != 0), 128'(1));
      if (exp_addrs.size() != 0) chk("cmd_addr", 128'(rd_addr_0), 128'(exp_addrs.pop_front()));
      chk("rd_len", 128'(rd_len_0), 128'(128));
      beat_left = short_next ? 127 : 128;
      burst_short = short_next;
      short_next = 0;
      lat = $urandom_range(4, 1);
    end
    if (do_start && c != 2'd3) begin
      if (n == 0) m_done = 1;
      else begin
        m_busy = 1;
        bursts_left = n;
        x = a;
        for (int i = 0; i < n; i++) begin
          exp_addrs.push_back(x);
          x = nxt(c, x);
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(0, 2'd0, '0, '0, 0);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((m_busy || q.size() != 0 || beat_left > 0) && k < 20000) begin
      step(0, 2'd0, '0, '0, 0);
      k++;
    end
    chk({name, "_timeout"}, 128'(k < 20000), 128'(1));
    idle(1);
  endtask

  task automatic chk_log3(input string name, input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    chk({name, "_ncmd"}, 128'(cmd_log.size()), 128'(3));
    chk({name, "_addr0"}, 128'(cmd_log.size() > 0 ? cmd_log[0] : 32'h0), 128'(a0));
    chk({name, "_addr1"}, 128'(cmd_log.size() > 1 ? cmd_log[1] : 32'h0), 128'(a1));
    chk({name, "_addr2"}, 128'(cmd_log.size() > 2 ? cmd_log[2] : 32'h0), 128'(a2));
  endtask

  initial begin
    int k;
    logic [1:0] c;
    logic [31:0] a;
    repeat (3) step(0, 2'd0, '0, '0, 1);
    chk_en = 1;
    idle(1);
    chk("reset_addr", 128'(rd_addr_0), 128'(32'h80000000));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_count", 128'(fifo_count), 128'(0));
    // straight run of three CH1 bursts
    cmd_log.delete(); pop_cnt = 0; done_cnt = 0;
    step(1, 2'd0, 32'h80000000, 16'd3, 0);
    wait_idle("t1");
    chk_log3("t1", 32'h80000000, 32'h80000080, 32'h80000100);
    chk("t1_beats", 128'(pop_cnt), 128'(384));
    chk("t1_done", 128'(done_cnt), 128'(1));
    // CH2 wrap at end of region with random handshakes
    cmd_log.delete(); or_mode = 2; rdy_mode = 0;
    step(1, 2'd1, 32'hBFFFFF00, 16'd3, 0);
    wait_idle("t2");
    chk_log3("t2", 32'hBFFFFF00, 32'hBFFFFF80, 32'hA0000000);
    // consumer stalled: third burst must wait for FIFO credit
    cmd_log.delete(); or_mode = 0; rdy_mode = 1;
    step(1, 2'd0, 32'h80000000, 16'd3, 0);
    k = 0;
    while (!(cmd_log.size() == 2 && beat_left == 0) && k < 3000) begin idle(1); k++; end
    chk("t3_wait", 128'(k < 3000), 128'(1));
    idle(20);
    chk("t3_full", 128'(fifo_count), 128'(256));
    chk("t3_held", 128'(cmd_log.size()), 128'(2));
    chk("t3_novalid", 128'(rd_valid_0), 128'(0));
    or_mode = 1;
    wait_idle("t3");
    chk("t3_ncmd", 128'(cmd_log.size()), 128'(3));
    // controller holds rd_ready_0 low for 10 cycles
    cmd_log.delete(); rdy_mode = 2; stall_seen = 0;
    step(1, 2'd2, 32'hBFFFFF80, 16'd1, 0);
    wait_idle("t4");
    chk("t4_stall", 128'(stall_seen), 128'(10));
    chk("t4_ncmd", 128'(cmd_log.size()), 128'(1));
    chk("t4_addr", 128'(cmd_log.size() > 0 ? cmd_log[0] : 32'h0), 128'(32'hBFFFFF80));
    // zero bursts and illegal channel
    rdy_mode = 1; cmd_log.delete(); done_cnt = 0;
    step(1, 2'd0, 32'h80000000, 16'd0, 0);
    idle(5);
    chk("t5_zero_done", 128'(done_cnt), 128'(1));
    chk("t5_zero_cmd", 128'(cmd_log.size()), 128'(0));
    done_cnt = 0;
    step(1, 2'd3, 32'h80000000, 16'd2, 0);
    idle(5);
    chk("t5_ill_done", 128'(done_cnt), 128'(0));
    chk("t5_ill_busy", 128'(busy), 128'(0));
    chk("t5_ill_cmd", 128'(cmd_log.size()), 128'(0));
    // reset in the middle of a burst, then a normal run
    or_mode = 0;
    step(1, 2'd0, 32'h80001000, 16'd4, 0);
    k = 0;
    while (!(beat_left > 0 && beat_left < 100) && k < 3000) begin idle(1); k++; end
    chk("t6_wait", 128'(k < 3000), 128'(1));
    step(0, 2'd0, '0, '0, 1);
    step(0, 2'd0, '0, '0, 1);
    idle(1);
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_count", 128'(fifo_count), 128'(0));
    chk("t6_rdvalid", 128'(rd_valid_0), 128'(0));
    or_mode = 1; cmd_log.delete();
    step(1, 2'd0, 32'h80000000, 16'd2, 0);
    wait_idle("t6");
    chk("t6_ncmd", 128'(cmd_log.size()), 128'(2));
    chk("t6_addr1", 128'(cmd_log.size() > 1 ? cmd_log[1] : 32'h0), 128'(32'h80000080));
    // short burst of 127 beats
    short_next = 1;
    step(1, 2'd0, 32'h80000000, 16'd2, 0);
    wait_idle("t7");
    chk("t7_len_err", 128'(len_err), 128'(len_chk));
    // random runs
    or_mode = 2; rdy_mode = 0;
    for (int r = 0; r < 12; r++) begin
      c = 2'($urandom_range(2));
      a = (c == 2'd0 ? 32'h9FFFFF80 : 32'hBFFFFF80) - 32'($urandom_range(3) * 128);
      step(1, c, a, 16'($urandom_range(4)), 0);
      wait_idle("rnd");
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
